spi_tx_master: RTL and testbench
================================

Name: spi_tx_master

Overview:
Parametrised SPI transmit master, the successor to the fixed 8-bit serialiser. It takes words from the hash-table output stage over a valid/ready handshake and serialises them onto mosi. It generates sclk (programmable divider and CPOL/CPHA mode) and a framed active-low chip select. Multi-word bursts share one chip-select frame, so hash digests wider than one word go out as one transaction.

Parameters:
DATA_W, 8, bits per word (≥2)
CLK_DIV, 4, clk cycles per sclk half-period (≥1)
CPOL, 0, sclk idle level
CPHA, 0, 0 = data valid before leading edge; 1 = data changes on leading edge
LSB_FIRST, 1, 1 = bit 0 shifted first, 0 = MSB first
CS_GAP, 2, minimum clk cycles cs_n stays high between frames (≥1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_data  in  DATA_W  word to transmit, sampled only on handshake
in_valid  in  1  in_data valid
in_last  in  1  word is last of frame, sampled with in_data
in_ready  out  1  block accepts a word this cycle
sclk  out  1  SPI clock
mosi  out  1  serial data
cs_n  out  1  active-low chip select
busy  out  1  high from accept until GAP completes

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All outputs registered.
- Reset values: sclk=CPOL, mosi=0, cs_n=1, in_ready=0, busy=0, state=GAP with gap counter cleared. in_ready rises CS_GAP cycles after rst drops.
- Handshake: transfer occurs when in_valid && in_ready. in_valid is ignored while in_ready=0. in_data and in_last are captured into the shift register and last flag.
- States: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
- IDLE: in_ready=1. On accept, go to SETUP. cs_n=0 and busy=1 from the next cycle. For CPHA=0, mosi = first bit from the same cycle.
- SETUP: lasts CLK_DIV cycles (cs-to-first-edge), sclk=CPOL.
- SHIFT: 2*DATA_W half-periods of CLK_DIV cycles each. sclk toggles at the end of each half-period.
  - CPHA=0: mosi advances on each trailing edge, except after the final edge.
  - CPHA=1: mosi is driven on each leading edge, including the first.
  - The bit order follows LSB_FIRST.
- Word end: in_ready=1 during the last clk cycle of the final half-period, but only if the last flag is 0.
  - Accept in that cycle: reload, stay in SHIFT with no SETUP, cs_n stays low, back-to-back sclk.
  - No accept and last flag = 0: go to WAIT.
  - Last flag = 1: go to HOLD.
- WAIT: in_ready=1, sclk=CPOL, cs_n=0 (frame held open). On accept, reload and go to SETUP.
- HOLD: CLK_DIV cycles with cs_n=0, then cs_n=1. Go to GAP.
- GAP: cs_n=1, in_ready=0 for CS_GAP cycles, then IDLE. busy drops on entry to IDLE.
- Single-word frame latency: cs_n low for 2*CLK_DIV*(DATA_W+1) cycles.
- mosi is 0 whenever cs_n=1.
- Reset mid-frame: on the next edge, cs_n=1, sclk=CPOL, mosi=0, the frame is aborted and the partial word discarded.
- Counters: half-period counter $clog2(CLK_DIV) bits (min 1). Edge counter $clog2(2*DATA_W) bits. Wrap from terminal count to 0; no overflow is possible.

Decomposition:
- Package spi_pkg holds:
  - the state enum (spi_state_t: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP)
  - constants SPI_MODE0..3 as {CPOL,CPHA} pairs
  - a function computing counter widths.
- One sub-module, spi_sclk_gen: half-period tick counter plus sclk register. Inputs are run and CPOL; outputs are lead_edge/trail_edge strobes, one clk wide.
- The FSM, shift register and handshake stay in spi_tx_master.

Test Plan:
- Mode 0, DATA_W=8, CLK_DIV=2, LSB_FIRST=1, send 0xA5 with in_last=1.
  - mosi sampled on sclk rises: 1,0,1,0,0,1,0,1.
  - Exactly 8 rising edges; cs_n low 36 cycles, then high ≥2 cycles.
  - in_ready=0 until IDLE.
- Mode 3 (CPOL=1, CPHA=1), LSB_FIRST=0, send 0x3C.
  - sclk idles 1; bits sampled on rising (trailing) edges: 0,0,1,1,1,1,0,0.
- Burst of 0x12 (last=0) then 0x34 (last=1), valid held high.
  - cs_n stays low throughout; 16 contiguous edges with no gap between words.
  - mosi = 0x12 then 0x34, LSB first.
- Burst with stalled source: 0x12 (last=0), then in_valid low for 10 cycles.
  - Block sits in WAIT: sclk=CPOL, cs_n=0, in_ready=1.
  - 0x34 (last=1) then sends after SETUP.
- Assert rst for 1 cycle at edge 5 of 0xFF.
  - Next cycle: cs_n=1, sclk=CPOL, mosi=0, busy=0.
  - After CS_GAP cycles in_ready=1; a following 0x01 transmits correctly.
- CLK_DIV=1, DATA_W=16, send 0xBEEF.
  - sclk toggles every clk; cs_n low 34 cycles; correct bit order.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding, SPI mode constants and counter sizing for the SPI transmit master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD,
        GAP
    } spi_state_t;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int spi_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period tick counter and sclk register, with one-cycle edge strobes.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic cpol,
    output logic sclk,
    output logic lead_edge,
    output logic trail_edge,
    output logic pre_edge
);

    localparam int HW = spi_cnt_w(CLK_DIV);
    localparam logic [HW-1:0] HP_LAST = HW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HP_PRE  = HW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

    logic [HW-1:0] cnt;
    logic          tick;

    assign tick       = run && (cnt == HP_LAST);
    assign lead_edge  = tick && (sclk == cpol);
    assign trail_edge = tick && (sclk != cpol);
    // High when the following cycle ends a half-period, assuming run stays high.
    assign pre_edge   = (CLK_DIV == 1) ? 1'b1 : (run && (cnt == HP_PRE));

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt  <= '0;
            sclk <= cpol;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_tx_master.sv
// SPI transmit master: valid/ready word intake, framed chip select, multi-word bursts in one frame.
module spi_tx_master
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 1,
    parameter int CS_GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy
);

    localparam int EW = spi_cnt_w(2 * DATA_W);
    localparam int DW = spi_cnt_w((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);
    localparam logic [DW-1:0] HP_END    = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] GAP_END   = DW'(CS_GAP - 1);
    localparam logic          CPOL_BIT  = (CPOL != 0);

    spi_state_t        state, state_next;
    logic [DW-1:0]     dly_cnt;
    logic [EW-1:0]     edge_cnt, edge_cnt_next;
    logic [DATA_W-1:0] shreg;
    logic              last_flag, last_next;
    logic              run, lead_edge, trail_edge, pre_edge;
    logic              accept, word_end, shift_en;
    logic              cs_n_d, busy_d, in_ready_d, mosi_d;

    function automatic logic head(input logic [DATA_W-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
        return (LSB_FIRST != 0) ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction

    assign run      = (state == SHIFT);
    assign accept   = in_valid && in_ready;
    assign word_end = run && trail_edge && (edge_cnt == EDGE_LAST);
    assign shift_en = run && ((CPHA == 0) ? (trail_edge && !word_end) : lead_edge);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cpol      (CPOL_BIT),
        .sclk      (sclk),
        .lead_edge (lead_edge),
        .trail_edge(trail_edge),
        .pre_edge  (pre_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= GAP;
            dly_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next == state && (state == SETUP || state == HOLD || state == GAP))
                dly_cnt <= dly_cnt + 1'b1;
            else
                dly_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = SETUP;
            SETUP: if (dly_cnt == HP_END) state_next = SHIFT;
            SHIFT: begin
                if (word_end) begin
                    if (last_flag)   state_next = HOLD;
                    else if (accept) state_next = SHIFT;
                    else             state_next = WAIT;
                end
            end
            WAIT:  if (accept) state_next = SETUP;
            HOLD:  if (dly_cnt == HP_END) state_next = GAP;
            GAP:   if (dly_cnt == GAP_END) state_next = IDLE;
            default: state_next = GAP;
        endcase
    end

    // in_ready is registered, so the word-end cycle is predicted one cycle ahead.
    always_comb begin
        last_next     = accept ? in_last : last_flag;
        edge_cnt_next = edge_cnt;
        if (!run || word_end)
            edge_cnt_next = '0;
        else if (lead_edge || trail_edge)
            edge_cnt_next = edge_cnt + 1'b1;

        cs_n_d     = (state_next == IDLE) || (state_next == GAP);
        busy_d     = (busy || accept) && (state_next != IDLE);
        in_ready_d = (state_next == IDLE) || (state_next == WAIT) ||
                     ((state_next == SHIFT) && pre_edge && (edge_cnt_next == EDGE_LAST) && !last_next);

        mosi_d = mosi;
        if (cs_n_d)
            mosi_d = 1'b0;
        else if (accept) begin
            if (CPHA == 0) mosi_d = head(in_data);
        end else if (shift_en)
            mosi_d = head(shreg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            mosi      <= 1'b0;
            edge_cnt  <= '0;
            shreg     <= '0;
            last_flag <= 1'b0;
        end else begin
            cs_n     <= cs_n_d;
            busy     <= busy_d;
            in_ready <= in_ready_d;
            mosi     <= mosi_d;
            edge_cnt <= edge_cnt_next;
            if (accept) begin
                shreg     <= (CPHA == 0) ? advance(in_data) : in_data;
                last_flag <= in_last;
            end else if (shift_en) begin
                shreg <= advance(shreg);
            end
        end
    end

endmodule

// File: tb/tb_spi_tx_master.sv
// Directed bench for spi_tx_master: mode 0, mode 3 MSB-first and a 16-bit CLK_DIV=1 instance.
module tb_spi_tx_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] tx_data [3];
    logic [2:0]  tx_valid, tx_last;
    logic [2:0]  rdy_v, sclk_v, mosi_v, cs_v, busy_v;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spi_tx_master #(
        .DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .LSB_FIRST(1), .CS_GAP(2)
    ) u_m0 (
        .clk(clk), .rst(rst), .in_data(tx_data[0][7:0]), .in_valid(tx_valid[0]),
        .in_last(tx_last[0]), .in_ready(rdy_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]),
        .cs_n(cs_v[0]), .busy(busy_v[0])
    );

    spi_tx_master #(
        .DATA_W(8), .CLK_DIV(2), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .CS_GAP(2)
    ) u_m3 (
        .clk(clk), .rst(rst), .in_data(tx_data[1][7:0]), .in_valid(tx_valid[1]),
        .in_last(tx_last[1]), .in_ready(rdy_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]),
        .cs_n(cs_v[1]), .busy(busy_v[1])
    );

    spi_tx_master #(
        .DATA_W(16), .CLK_DIV(1), .CPOL(0), .CPHA(0), .LSB_FIRST(1), .CS_GAP(2)
    ) u_w16 (
        .clk(clk), .rst(rst), .in_data(tx_data[2]), .in_valid(tx_valid[2]),
        .in_last(tx_last[2]), .in_ready(rdy_v[2]), .sclk(sclk_v[2]), .mosi(mosi_v[2]),
        .cs_n(cs_v[2]), .busy(busy_v[2])
    );

    // Line monitor: mosi captured on every sclk rise, cs_n low-run length, widest rise spacing.
    int          rises [3];
    logic [31:0] bits [3];
    int          cs_len [3];
    int          cs_done [3];
    int          last_rise [3];
    int          max_int [3];
    logic [2:0]  prev_sclk = '0;
    int          cyc = 0;
    logic        mon_clr = 1'b1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        prev_sclk <= sclk_v;
        for (int k = 0; k < 3; k++) begin
            if (mon_clr) begin
                rises[k]   <= 0;
                bits[k]    <= '0;
                cs_len[k]  <= 0;
                cs_done[k] <= 0;
                max_int[k] <= 0;
            end else begin
                if (!cs_v[k])
                    cs_len[k] <= cs_len[k] + 1;
                else if (cs_len[k] != 0) begin
                    cs_done[k] <= cs_len[k];
                    cs_len[k]  <= 0;
                end
                if (sclk_v[k] && !prev_sclk[k]) begin
                    if (rises[k] < 32) bits[k][rises[k]] <= mosi_v[k];
                    if (rises[k] > 0 && (cyc - last_rise[k]) > max_int[k])
                        max_int[k] <= cyc - last_rise[k];
                    rises[k]     <= rises[k] + 1;
                    last_rise[k] <= cyc;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic mon_reset();
        mon_clr = 1'b1;
        @(negedge clk);
        @(posedge clk);
        mon_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input int k, input logic [15:0] d, input logic l, input bit hold_valid);
        int n = 0;
        tx_data[k]  = d;
        tx_last[k]  = l;
        tx_valid[k] = 1'b1;
        while (!rdy_v[k] && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (!hold_valid) tx_valid[k] = 1'b0;
        check("accept_wait", 32'(n < 500), 32'd1);
    endtask

    task automatic wait_done(input int k, output int gap_n, output int rdy_n);
        int n = 0;
        gap_n = 0;
        rdy_n = 0;
        while (busy_v[k] && n < 2000) begin
            if (cs_v[k])  gap_n++;
            if (rdy_v[k]) rdy_n++;
            @(negedge clk);
            n++;
        end
        check("done_wait", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int gap_n, rdy_n, n;
        rst = 1'b1;
        tx_valid = '0;
        tx_last  = '0;
        for (int k = 0; k < 3; k++) tx_data[k] = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs_n",  32'(cs_v),   32'h7);
        check("rst_sclk",  32'(sclk_v), 32'h2);
        check("rst_mosi",  32'(mosi_v), 32'h0);
        check("rst_ready", 32'(rdy_v),  32'h0);
        check("rst_busy",  32'(busy_v), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("gap_ready_lo", 32'(rdy_v), 32'h0);
        @(negedge clk);
        check("gap_ready_hi", 32'(rdy_v), 32'h7);
        mon_reset();

        // Mode 0, single word 0xA5, LSB first
        send(0, 16'h00A5, 1'b1, 1'b0);
        check("m0_busy", 32'(busy_v[0]), 32'd1);
        check("m0_cs_lo", 32'(cs_v[0]), 32'd0);
        wait_done(0, gap_n, rdy_n);
        check("m0_bits",   bits[0][7:0], 32'hA5);
        check("m0_rises",  32'(rises[0]), 32'd8);
        check("m0_cs_len", 32'(cs_done[0]), 32'd36);
        check("m0_gap",    32'(gap_n), 32'd2);
        check("m0_rdy_busy", 32'(rdy_n), 32'd0);
        check("m0_idle_rdy", 32'(rdy_v[0]), 32'd1);

        // Mode 3, MSB first
        mon_reset();
        send(1, 16'h003C, 1'b1, 1'b0);
        wait_done(1, gap_n, rdy_n);
        check("m3_bits",  bits[1][7:0], 32'h3C);
        check("m3_rises", 32'(rises[1]), 32'd8);
        check("m3_idle_sclk", 32'(sclk_v[1]), 32'd1);
        mon_reset();
        send(1, 16'h0001, 1'b1, 1'b0);
        wait_done(1, gap_n, rdy_n);
        check("m3_msb_order", bits[1][7:0], 32'h80);

        // Back-to-back burst with valid held high
        mon_reset();
        send(0, 16'h0012, 1'b0, 1'b1);
        send(0, 16'h0034, 1'b1, 1'b0);
        wait_done(0, gap_n, rdy_n);
        check("b2b_bits",   bits[0][15:0], 32'h3412);
        check("b2b_rises",  32'(rises[0]), 32'd16);
        check("b2b_cs_len", 32'(cs_done[0]), 32'd68);
        check("b2b_period", 32'(max_int[0]), 32'd4);

        // Burst with a stalled source
        mon_reset();
        send(0, 16'h0012, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        check("wait_sclk",  32'(sclk_v[0]), 32'd0);
        check("wait_cs_n",  32'(cs_v[0]),   32'd0);
        check("wait_ready", 32'(rdy_v[0]),  32'd1);
        check("wait_busy",  32'(busy_v[0]), 32'd1);
        check("wait_rises", 32'(rises[0]),  32'd8);
        send(0, 16'h0034, 1'b1, 1'b0);
        wait_done(0, gap_n, rdy_n);
        check("stall_bits",  bits[0][15:0], 32'h3412);
        check("stall_rises", 32'(rises[0]), 32'd16);
        check("stall_pause", 32'(max_int[0] > 4), 32'd1);

        // Reset mid-frame at edge 5 of 0xFF
        mon_reset();
        send(0, 16'h00FF, 1'b1, 1'b0);
        n = 0;
        while (rises[0] < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach", 32'(n < 200), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_cs_n", 32'(cs_v[0]),   32'd1);
        check("abort_sclk", 32'(sclk_v[0]), 32'd0);
        check("abort_mosi", 32'(mosi_v[0]), 32'd0);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        check("abort_rdy_lo", 32'(rdy_v[0]), 32'd0);
        @(negedge clk);
        check("abort_rdy_hi", 32'(rdy_v[0]), 32'd1);
        mon_reset();
        send(0, 16'h0001, 1'b1, 1'b0);
        wait_done(0, gap_n, rdy_n);
        check("post_abort_bits",  bits[0][7:0], 32'h01);
        check("post_abort_rises", 32'(rises[0]), 32'd8);
        check("post_abort_cs",    32'(cs_done[0]), 32'd36);

        // CLK_DIV=1, 16-bit word
        mon_reset();
        send(2, 16'hBEEF, 1'b1, 1'b0);
        wait_done(2, gap_n, rdy_n);
        check("w16_bits",   bits[2][15:0], 32'hBEEF);
        check("w16_rises",  32'(rises[2]), 32'd16);
        check("w16_cs_len", 32'(cs_done[2]), 32'd34);
        check("w16_period", 32'(max_int[2]), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
